// File: rtl/serial_product_collector.sv
// rtl/serial_product_collector.sv - assembles a bit-serial product stream into a parallel word behind a valid/ready buffer
module serial_product_collector #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SIN,
    output logic [WIDTH-1:0] P_DATA,
    output logic             P_VALID,
    input  logic             P_READY,
    output logic             BUSY,
    output logic             OVERRUN
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic             complete;

    // Writes serial bit number k into its product position for the chosen bit order.
    function automatic logic [WIDTH-1:0] place_bit(
        input logic [WIDTH-1:0] base,
        input logic [CW-1:0]    k,
        input logic             b
    );
        logic [WIDTH-1:0] r;
        int               pos;
        r   = base;
        pos = MSB_FIRST ? (WIDTH - 1 - int'(k)) : int'(k);
        for (int i = 0; i < WIDTH; i++) begin
            if (i == pos) begin
                r[i] = b;
            end
        end
        return r;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            count <= '0;
            shreg <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            shreg <= shreg_next;
        end
    end

    // START always wins, including on what would have been the completion cycle.
    always_comb begin
        state_next = state;
        count_next = count;
        shreg_next = shreg;
        complete   = 1'b0;
        if (START) begin
            state_next = SHIFT;
            count_next = CW'(1);
            shreg_next = place_bit('0, '0, SIN);
        end else if (state == SHIFT) begin
            shreg_next = place_bit(shreg, count, SIN);
            if (count == CW'(WIDTH - 1)) begin
                complete   = 1'b1;
                state_next = IDLE;
                count_next = '0;
            end else begin
                count_next = count + CW'(1);
            end
        end
    end

    always_comb begin
        BUSY = (state == SHIFT);
    end

    // A completing frame loads only if the held word is absent or being consumed now.
    always_ff @(posedge CLK) begin
        if (RST) begin
            P_DATA  <= '0;
            P_VALID <= 1'b0;
            OVERRUN <= 1'b0;
        end else if (complete) begin
            if (!P_VALID || P_READY) begin
                P_DATA  <= shreg_next;
                P_VALID <= 1'b1;
            end else begin
                OVERRUN <= 1'b1;
            end
        end else if (P_VALID && P_READY) begin
            P_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_product_collector.sv
// tb/tb_serial_product_collector.sv - self-checking bench for serial_product_collector, both bit orders
module tb_serial_product_collector;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sin;
    logic       p_ready;
    logic [7:0] d0_data, d1_data;
    logic       d0_valid, d1_valid, d0_busy, d1_busy, d0_ovr, d1_ovr;

    int checks = 0;
    int errors = 0;

    serial_product_collector #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .CLK(clk), .RST(rst), .START(start), .SIN(sin),
        .P_DATA(d0_data), .P_VALID(d0_valid), .P_READY(p_ready),
        .BUSY(d0_busy), .OVERRUN(d0_ovr)
    );

    serial_product_collector #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .CLK(clk), .RST(rst), .START(start), .SIN(sin),
        .P_DATA(d1_data), .P_VALID(d1_valid), .P_READY(p_ready),
        .BUSY(d1_busy), .OVERRUN(d1_ovr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect serial bits in a queue, build the word once eight have arrived.
    bit         m_init = 1'b0;
    bit         q[$];
    logic [7:0] m_data0, m_data1;
    bit         m_valid, m_ovr, m_busy;

    always @(posedge clk) begin
        bit         done;
        logic [7:0] w0, w1;
        if (rst) begin
            m_init  = 1'b1;
            q.delete();
            m_data0 = 8'h00;
            m_data1 = 8'h00;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_busy  = 1'b0;
        end else begin
            done = 1'b0;
            w0   = 8'h00;
            w1   = 8'h00;
            if (start) begin
                q.delete();
                q.push_back(sin);
            end else if (q.size() > 0) begin
                q.push_back(sin);
            end
            if (q.size() == 8) begin
                done = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    w0[i]     = q[i];
                    w1[7 - i] = q[i];
                end
                q.delete();
            end
            if (done) begin
                if (!m_valid || p_ready) begin
                    m_data0 = w0;
                    m_data1 = w1;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && p_ready) begin
                m_valid = 1'b0;
            end
            m_busy = (q.size() > 0);
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("lsb_data", d0_data, m_data0);
            chk("lsb_valid", d0_valid, m_valid);
            chk("lsb_busy", d0_busy, m_busy);
            chk("lsb_ovr", d0_ovr, m_ovr);
            chk("msb_data", d1_data, m_data1);
            chk("msb_valid", d1_valid, m_valid);
            chk("msb_busy", d1_busy, m_busy);
            chk("msb_ovr", d1_ovr, m_ovr);
        end
    end

    // stream[k] is the k-th serial bit; the last bit is driven when this returns.
    task automatic send_frame(input logic [7:0] stream, input bit rdy_last);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start = (k == 0);
            sin   = stream[k];
            if (k == 7 && rdy_last) p_ready = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0;
            sin   = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        sin   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        sin     = 1'b0;
        p_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset state, SIN ignored without START
        @(negedge clk);
        chk("t1_data", d0_data, 8'h00);
        chk("t1_valid", d0_valid, 1'b0);
        chk("t1_busy", d0_busy, 1'b0);
        chk("t1_ovr", d0_ovr, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sin = i[0];
        end
        @(negedge clk);
        chk("t1_idle_valid", d0_valid, 1'b0);
        chk("t1_idle_busy", d0_busy, 1'b0);

        // 3 x 5 = 15, LSB first
        p_ready = 1'b1;
        send_frame(8'h0F, 1'b0);
        chk("t2_busy_mid", d0_busy, 1'b1);
        idle(1);
        chk("t2_data", d0_data, 8'h0F);
        chk("t2_valid", d0_valid, 1'b1);
        chk("t2_busy_end", d0_busy, 1'b0);
        idle(1);
        chk("t2_valid_drop", d0_valid, 1'b0);

        // back-to-back frames into a stalled consumer
        p_ready = 1'b0;
        send_frame(8'hE1, 1'b0);
        send_frame(8'h00, 1'b0);
        idle(1);
        chk("t3_data", d0_data, 8'hE1);
        chk("t3_valid", d0_valid, 1'b1);
        chk("t3_ovr", d0_ovr, 1'b1);
        @(negedge clk);
        p_ready = 1'b1;
        @(negedge clk);
        p_ready = 1'b0;
        chk("t3_valid_after", d0_valid, 1'b0);
        chk("t3_ovr_sticky", d0_ovr, 1'b1);
        chk("t3_data_hold", d0_data, 8'hE1);

        // simultaneous consume and load
        do_reset();
        send_frame(8'h0F, 1'b0);
        idle(1);
        chk("t4_pending", d0_data, 8'h0F);
        send_frame(8'h24, 1'b1);
        @(negedge clk);
        start   = 1'b0;
        sin     = 1'b0;
        p_ready = 1'b0;
        chk("t4_data", d0_data, 8'h24);
        chk("t4_valid", d0_valid, 1'b1);
        chk("t4_ovr", d0_ovr, 1'b0);

        // restart mid-frame, then reset mid-frame
        do_reset();
        p_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = (k == 0);
            sin   = 1'b1;
        end
        send_frame(8'h02, 1'b0);
        idle(1);
        chk("t5_data", d0_data, 8'h02);
        chk("t5_valid", d0_valid, 1'b1);
        chk("t5_ovr", d0_ovr, 1'b0);
        idle(1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = (k == 0);
            sin   = 1'b1;
        end
        do_reset();
        idle(6);
        chk("t5_rst_valid", d0_valid, 1'b0);
        send_frame(8'h6C, 1'b0);
        idle(1);
        chk("t5_clean_lsb", d0_data, 8'h6C);
        chk("t5_clean_msb", d1_data, 8'h36);

        // MSB first: serial 1,1,1,0,0,0,0,1
        idle(1);
        send_frame(8'h87, 1'b0);
        idle(1);
        chk("t6_msb_data", d1_data, 8'hE1);
        chk("t6_msb_valid", d1_valid, 1'b1);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 499) == 0);
            start   = ($urandom_range(0, 10) == 0);
            sin     = 1'($urandom);
            p_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        rst     = 1'b0;
        start   = 1'b0;
        p_ready = 1'b1;
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
